// File: rtl/axis_byte_word_packer.sv
// Byte-to-word packer for an AXI-Stream style byte stream: packs C_WORD_BYTES bytes
// per output word with a lane keep mask, flushing partial words on request or idle timeout.
module axis_byte_word_packer #(
  parameter int unsigned C_WORD_BYTES = 4,
  parameter int unsigned C_TIMEOUT    = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      aclken,
  input  logic [7:0]                s_mesg,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      flush,
  output logic [8*C_WORD_BYTES-1:0] m_data,
  output logic [C_WORD_BYTES-1:0]   m_keep,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam int unsigned CW = $clog2(C_WORD_BYTES);
  localparam int unsigned TW = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam int unsigned AW = 8 * (C_WORD_BYTES - 1);
  localparam logic [CW-1:0] LAST = CW'(C_WORD_BYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(C_TIMEOUT);

  localparam logic [2:0] ST_EMPTY    = 3'd0;
  localparam logic [2:0] ST_FILL     = 3'd1;
  localparam logic [2:0] ST_OUT      = 3'd2;
  localparam logic [2:0] ST_FILL_OUT = 3'd3;
  localparam logic [2:0] ST_STALL    = 3'd4;

  logic [AW-1:0]             acc;
  logic [CW-1:0]             count;
  logic [TW-1:0]             timer;
  logic                      flush_pend;
  logic                      rst_hold;
  logic [2:0]                state;
  logic                      s_hs;
  logic                      m_hs;
  logic                      full_load;
  logic                      tmo;
  logic                      do_flush;
  logic [8*C_WORD_BYTES-1:0] flush_data;
  logic [C_WORD_BYTES-1:0]   flush_keep;

  // State is a pure decode of count/m_valid; STALL is the only state that blocks input.
  always_comb begin
    state = ST_EMPTY;
    if (count == '0)
      state = m_valid ? ST_OUT : ST_EMPTY;
    else if (!m_valid)
      state = ST_FILL;
    else if (count == LAST)
      state = ST_STALL;
    else
      state = ST_FILL_OUT;
  end

  assign s_ready   = ~rst_hold & (state != ST_STALL);
  assign s_hs      = aclken & s_valid & s_ready;
  assign m_hs      = aclken & m_valid & m_ready;
  assign full_load = s_hs & (count == LAST);
  assign tmo       = (C_TIMEOUT != 0) && (timer == TMAX);
  assign do_flush  = aclken & (flush | flush_pend | tmo) & (count != '0) & ~s_hs
                   & (~m_valid | m_ready);

  always_comb begin
    flush_data = '0;
    flush_keep = '0;
    for (int unsigned k = 0; k < C_WORD_BYTES - 1; k++) begin
      if (CW'(k) < count) begin
        flush_data[8*k +: 8] = acc[8*k +: 8];
        flush_keep[k]        = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      rst_hold <= 1'b1;
    else
      rst_hold <= 1'b0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc        <= '0;
      count      <= '0;
      timer      <= '0;
      flush_pend <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_valid    <= 1'b0;
    end else if (aclken) begin
      if (full_load) begin
        m_data  <= {s_mesg, acc};
        m_keep  <= '1;
        m_valid <= 1'b1;
        count   <= '0;
      end else if (do_flush) begin
        m_data  <= flush_data;
        m_keep  <= flush_keep;
        m_valid <= 1'b1;
        count   <= '0;
      end else begin
        if (m_hs)
          m_valid <= 1'b0;
        if (s_hs)
          count <= count + CW'(1);
      end

      for (int unsigned k = 0; k < C_WORD_BYTES - 1; k++) begin
        if (s_hs && (count == CW'(k)))
          acc[8*k +: 8] <= s_mesg;
      end

      // A completed word leaves nothing behind, so it also retires any pending flush.
      if (do_flush || full_load)
        flush_pend <= 1'b0;
      else if (flush && (count != '0))
        flush_pend <= 1'b1;

      if (s_hs || (count == '0) || do_flush)
        timer <= '0;
      else if ((C_TIMEOUT != 0) && (timer != TMAX))
        timer <= timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_axis_byte_word_packer.sv
// Scoreboard bench for axis_byte_word_packer: a byte-level model predicts each output
// word at drive time; a monitor pops and compares on every output handshake.
module tb_axis_byte_word_packer;

  localparam int unsigned W  = 4;
  localparam int unsigned TO = 16;

  logic           aclk;
  logic           areset;
  logic           aclken;
  logic [7:0]     s_mesg;
  logic           s_valid;
  logic           s_ready;
  logic           flush;
  logic [8*W-1:0] m_data;
  logic [W-1:0]   m_keep;
  logic           m_valid;
  logic           m_ready;

  axis_byte_word_packer #(.C_WORD_BYTES(W), .C_TIMEOUT(TO)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .aclken  (aclken),
    .s_mesg  (s_mesg),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .flush   (flush),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]      mdl[$];
  logic [8*W+W-1:0] sb[$];
  logic            tog = 1'b0;
  logic            watch = 1'b0;
  logic            chk_int = 1'b0;
  logic            have_prev = 1'b0;
  int              drops = 0;
  int              cyc = 0;
  int              prev_cyc = 0;
  logic            prev_stall = 1'b0;
  logic [8*W+W:0]  prev_word = '0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_word();
    logic [8*W-1:0] d;
    logic [W-1:0]   k;
    d = '0;
    k = '0;
    for (int i = 0; i < mdl.size(); i++) begin
      d[8*i +: 8] = mdl[i];
      k[i]        = 1'b1;
    end
    sb.push_back({k, d});
    mdl.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    logic ok;
    ok = 1'b0;
    s_mesg  = b;
    s_valid = 1'b1;
    flush   = fl;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge aclk);
      ok = aclken && s_ready;
      @(posedge aclk);
      #1;
      flush = 1'b0;
    end
    check("send_accept", ok, 1);
    if (ok) begin
      mdl.push_back(b);
      if (mdl.size() == W) push_word();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge aclk);
      #2;
      n++;
    end
    check("drain", 64'(sb.size()), 0);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // aclken driver: steady high, or alternating each cycle when tog is set.
  initial begin
    aclken = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      aclken = tog ? ~aclken : 1'b1;
    end
  end

  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (watch && !s_ready) drops++;
      if (prev_stall) check("hold_stable", {m_valid, m_keep, m_data}, prev_word);
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_valid, m_keep, m_data};
      if (aclken && m_valid && m_ready) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          logic [8*W+W-1:0] e;
          e = sb.pop_front();
          check("m_data", m_data, e[8*W-1:0]);
          check("m_keep", m_keep, e[8*W+W-1:8*W]);
        end
        if (chk_int && have_prev) check("interval", 64'(cyc - prev_cyc), 4);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset  = 1'b1;
    s_mesg  = '0;
    s_valid = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 0);
    repeat (3) step();
    areset = 1'b0;
    check("rst_hold_s_ready", s_ready, 0);
    step();
    check("post_rst_s_ready", s_ready, 1);

    // single word
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    check("pre_word_valid", m_valid, 0);
    send_byte(8'h44, 0);
    s_valid = 1'b0;
    check("word_latency", m_valid, 1);
    check("word1_data", m_data, 32'h44332211);
    wait_drain();

    // continuous stream
    watch = 1'b1; chk_int = 1'b1; have_prev = 1'b0; drops = 0;
    for (int i = 0; i < 12; i++) send_byte(8'(i), 0);
    s_valid = 1'b0;
    wait_drain();
    watch = 1'b0; chk_int = 1'b0;
    check("sready_drops", 64'(drops), 0);

    // back-pressure into STALL
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 0);
    s_valid = 1'b0;
    check("stall_s_ready", s_ready, 0);
    repeat (3) step();
    check("stall_s_ready_held", s_ready, 0);
    check("stall_word1", m_data, 32'h53525150);
    m_ready = 1'b1;
    send_byte(8'h57, 0);
    s_valid = 1'b0;
    wait_drain();

    // idle timeout flush
    begin
      int k;
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      s_valid = 1'b0;
      push_word();
      k = 0;
      while (!m_valid && k < 40) begin
        step();
        k++;
      end
      check("timeout_lat", 64'(k), TO + 1);
      check("timeout_data", m_data, 32'h0000BBAA);
      wait_drain();
    end

    // explicit flush at idle cycle 3
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    s_valid = 1'b0;
    push_word();
    step();
    step();
    check("flush_early_valid", m_valid, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_lat", m_valid, 1);
    check("flush_keep", m_keep, 4'h3);
    wait_drain();

    // flush coincident with an input byte becomes pending
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 1);
    s_valid = 1'b0;
    check("pend_not_yet", m_valid, 0);
    push_word();
    step();
    check("pend_valid", m_valid, 1);
    check("pend_data", m_data, 32'h00CCBBAA);
    wait_drain();

    // flush with nothing held is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("empty_flush_ignored", m_valid, 0);

    // stream at half rate via aclken
    tog = 1'b1;
    for (int i = 0; i < 12; i++) send_byte(8'(i), 0);
    s_valid = 1'b0;
    wait_drain();
    tog = 1'b0;
    step();

    // reset mid-word discards held bytes
    send_byte(8'h61, 0);
    send_byte(8'h62, 0);
    s_valid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    mdl.delete();
    step();
    areset = 1'b0;
    check("midrst_hold", s_ready, 0);
    step();
    for (int i = 0; i < 4; i++) send_byte(8'h71 + 8'(i), 0);
    s_valid = 1'b0;
    check("clean_word", m_data, 32'h74737271);
    wait_drain();

    repeat (3) step();
    check("sb_empty_end", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_byte_word_packer.md
Name: axis_byte_word_packer

Overview:
- Downstream neighbour of the 8-bit register-slice SRL FIFO; consumes its m_mesg/m_valid/m_ready byte stream.
- Packs consecutive bytes into C_WORD_BYTES-wide words with per-byte keep, one registered output word.
- Flushes a partial word on an explicit flush request or after an idle timeout, so trailing bytes are never stranded in the switch datapath.

Parameters:
- C_WORD_BYTES, 4, bytes per output word; legal range 2..8.
- C_TIMEOUT, 16, consecutive idle aclken cycles with a partial word held before auto-flush; 0 disables the timeout.

Ports:
- aclk  in  1  clock
- areset  in  1  reset; one clock; reset is asynchronous and active-high
- aclken  in  1  clock enable; when low, all state holds and no handshake completes
- s_mesg  in  8  input byte
- s_valid  in  1  input byte valid
- s_ready  out  1  input ready; registered-state-derived, with no combinational path from m_ready or s_valid
- flush  in  1  single-cycle request to emit the partial word
- m_data  out  8*C_WORD_BYTES  output word; byte k in lane k (bits 8k+7:8k)
- m_keep  out  C_WORD_BYTES  lane-valid mask, contiguous from lane 0
- m_valid  out  1  output word valid
- m_ready  in  1  output ready

Behaviour:
- Reset (async assert, sync release): count=0, timer=0, m_valid=0, m_keep=0, m_data=0, s_ready=0 for the first clock after release, then 1. Asserting reset mid-word discards held bytes.
- State: accumulator acc (C_WORD_BYTES-1 bytes), count (0..C_WORD_BYTES-1), output register {m_data, m_keep, m_valid}, idle timer.
- s_ready = ~rst_hold & ((count != C_WORD_BYTES-1) | ~m_valid).
- Handshakes complete only on an aclk edge with aclken=1.
- Input handshake (s_valid & s_ready):
  - count < C_WORD_BYTES-1: store the byte into acc lane[count], count+1.
  - count == C_WORD_BYTES-1: load the output register with {byte, acc} and keep = all ones; set m_valid=1; count=0.
  - Latency: last byte accepted -> m_valid on the next edge.
- Output handshake (m_valid & m_ready): m_valid clears unless a new word loads in the same cycle, in which case m_valid stays 1 with the new data. There are no bubbles at 1 byte/cycle input with m_ready=1.
- Flush condition F: (flush pulse, or timer == C_TIMEOUT with C_TIMEOUT != 0) AND count > 0 AND no input handshake this cycle AND (~m_valid | m_ready).
  - On F: output register gets acc lanes 0..count-1; unused lanes 0; keep = (1<<count)-1; count=0; timer=0.
- Flush arriving while the output register is busy, or in the same cycle as an input handshake: latched as flush_pend, which is serviced at the first cycle F is satisfiable. The pending request is cleared if a full word completes first (nothing left to flush). A flush with count=0 is ignored.
- Timer:
  - Resets to 0 on any input handshake or when count=0.
  - Otherwise increments per aclken cycle, saturating at C_TIMEOUT.
- Output stability: m_data/m_keep/m_valid are held stable while m_valid=1 and m_ready=0 (AXI-Stream rule).
- FSM, derived from count/m_valid:
  - EMPTY (count=0, ~m_valid)
  - FILL (count>0, ~m_valid)
  - OUT (count=0, m_valid)
  - FILL_OUT (count>0, m_valid)
  - STALL (count=C_WORD_BYTES-1, m_valid, s_ready=0)
  - STALL exits to FILL_OUT/FILL only via an output handshake; the next byte then completes a word.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 back-to-back with m_ready=1 -> one word m_data=0x44332211, m_keep=0xF, m_valid one cycle after 0x44 accepted.
- 12 continuous bytes 0x00..0x0B, m_ready=1 -> words 0x03020100, 0x07060504, 0x0B0A0908 on consecutive 4-cycle intervals; s_ready never drops.
- m_ready=0, send 8 bytes -> first word held stable; s_ready drops after 3 bytes of the second word (STALL). Raise m_ready -> both words emitted in order, no data loss.
- Bytes 0xAA,0xBB then idle, C_TIMEOUT=16 -> after 16 idle cycles m_data=0x0000BBAA, m_keep=0x3. Repeat with a flush pulse at idle cycle 3 -> emitted at cycle 4.
- Flush pulse in the same cycle as a third byte 0xCC (after 0xAA,0xBB) -> pending flush emits 0x00CCBBAA, keep=0x7, on the next cycle.
- aclken toggled 1/0 every cycle during scenario 2 -> identical word sequence at half rate. areset asserted after 2 bytes -> m_valid=0 and count=0 immediately; the next 4 bytes form a clean word.
